// File: rtl/ring_johnson_counter.sv
// rtl/ring_johnson_counter.sv - run-time selectable Johnson/ring shift counter
// with enable, direction, load, phase decode, wrap pulse and illegal-state recovery.
module ring_johnson_counter #(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] out_o,
  output logic [PW-1:0]    phase_o,
  output logic             wrap_o,
  output logic             illegal_o
);

  localparam logic [PW-1:0]    JPMAX   = PW'(2*WIDTH-1);
  localparam logic [PW-1:0]    RPMAX   = PW'(WIDTH-1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] out_inv;
  logic             legal_j, legal_r, illegal;
  logic [PW-1:0]    ones, ridx, phase_j, phase, pmax;

  always_comb begin
    ones = '0;
    ridx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + PW'(out_q[i]);
      if (out_q[i]) ridx = PW'(i);
    end
  end

  // Johnson states are a low-aligned run of ones, or the complement of one.
  assign out_inv = ~out_q;
  assign legal_j = ((out_q & (out_q + ONE)) == '0) || ((out_inv & (out_inv + ONE)) == '0);
  assign legal_r = (out_q != '0) && ((out_q & (out_q - ONE)) == '0);
  assign illegal = mode_i ? ~legal_r : ~legal_j;

  assign phase_j = out_q[WIDTH-1] ? (JPMAX - ones + PW'(1)) : ones;
  assign phase   = illegal ? '0 : (mode_i ? ridx : phase_j);
  assign pmax    = mode_i ? RPMAX : JPMAX;

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (load_i) begin
      out_d = load_val_i;
    end else if (en_i && illegal) begin
      out_d = mode_i ? ONE : '0;
    end else if (en_i) begin
      if (!dir_i) begin
        out_d  = {out_q[WIDTH-2:0], mode_i ? out_q[WIDTH-1] : ~out_q[WIDTH-1]};
        wrap_d = (phase == pmax);
      end else begin
        out_d  = {mode_i ? out_q[0] : ~out_q[0], out_q[WIDTH-1:1]};
        wrap_d = (phase == '0);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out_o     = out_q;
  assign phase_o   = phase;
  assign wrap_o    = wrap_q;
  assign illegal_o = illegal;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// tb/tb_ring_johnson_counter.sv - scoreboard bench for ring_johnson_counter
// using a table-driven sequence model.
module tb_ring_johnson_counter;

  localparam int W  = 4;
  localparam int PW = $clog2(2*W);

  logic          clk = 1'b0;
  logic          rst_n, en, mode, dir, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  out;
  logic [PW-1:0] phase;
  logic          wrap, illegal;

  typedef struct packed {
    logic [W-1:0]  out;
    logic [PW-1:0] phase;
    logic          wrap;
    logic          illegal;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_out;

  always #5 clk = ~clk;

  ring_johnson_counter #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .dir_i(dir),
    .load_i(load), .load_val_i(load_val), .out_o(out), .phase_o(phase),
    .wrap_o(wrap), .illegal_o(illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Left-shift sequence position p for the given mode.
  function automatic logic [W-1:0] gen(input logic m, input int p);
    logic [W-1:0] all1;
    all1 = '1;
    if (m) return W'(1) << p;
    if (p <= W) return W'((1 << p) - 1);
    return all1 << (p - W);
  endfunction

  function automatic int find(input logic m, input logic [W-1:0] v);
    int per;
    per = m ? W : 2*W;
    for (int p = 0; p < per; p++)
      if (gen(m, p) == v) return p;
    return -1;
  endfunction

  task automatic drive(input string tag, input logic e, input logic m, input logic d,
                       input logic l, input logic [W-1:0] v);
    exp_t         ex, got;
    int           p, per, pn;
    logic [W-1:0] nx;
    logic         wr;
    en = e; mode = m; dir = d; load = l; load_val = v;
    per = m ? W : 2*W;
    p   = find(m, m_out);
    nx  = m_out;
    wr  = 1'b0;
    if (l) nx = v;
    else if (e && p < 0) nx = m ? W'(1) : '0;
    else if (e) begin
      if (!d) begin wr = (p == per-1); nx = gen(m, (p+1) % per); end
      else    begin wr = (p == 0);     nx = gen(m, (p+per-1) % per); end
    end
    m_out      = nx;
    pn         = find(m, nx);
    ex.out     = nx;
    ex.phase   = (pn < 0) ? '0 : PW'(pn);
    ex.wrap    = wr;
    ex.illegal = (pn < 0);
    sb_q.push_back(ex);
    @(posedge clk); #1;
    got = sb_q.pop_front();
    check_eq({tag, "_out"},     32'(out),     32'(got.out));
    check_eq({tag, "_phase"},   32'(phase),   32'(got.phase));
    check_eq({tag, "_wrap"},    32'(wrap),    32'(got.wrap));
    check_eq({tag, "_illegal"}, 32'(illegal), 32'(got.illegal));
  endtask

  task automatic release_reset();
    en = 1'b0; load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_out = '0;
    @(posedge clk); #1;
    check_eq("rel_out", 32'(out), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    m_out = '0;
    #1;
    check_eq("rst_out", 32'(out), 32'h0);
    check_eq("rst_wrap", 32'(wrap), 32'h0);
    check_eq("rst_phase", 32'(phase), 32'h0);
    check_eq("rst_illegal_j", 32'(illegal), 32'h0);
    mode = 1'b1; #1;
    check_eq("rst_illegal_r", 32'(illegal), 32'h1);
    mode = 1'b0;
    // A load under reset must be lost.
    load = 1'b1; load_val = 4'b1010;
    @(posedge clk); #1;
    check_eq("rst_load_out", 32'(out), 32'h0);
    release_reset();

    // Johnson left full cycle.
    for (int i = 0; i < 8; i++) drive("jl", 1, 0, 0, 0, '0);
    check_eq("jl_end_wrap", 32'(wrap), 32'h1);
    for (int i = 0; i < 3; i++) drive("jl2", 1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) drive("hold", 0, 0, 0, 0, '0);
    check_eq("hold_out", 32'(out), 32'h7);
    drive("load1100", 0, 0, 0, 1, 4'b1100);

    // Ring right.
    drive("rload", 0, 1, 1, 1, 4'b0001);
    for (int i = 0; i < 4; i++) drive("rr", 1, 1, 1, 0, '0);

    // Illegal ring state and correction.
    drive("rill", 0, 1, 0, 1, 4'b0101);
    drive("rfix", 1, 1, 0, 0, '0);

    // Mode switch correction.
    drive("jload", 0, 0, 0, 1, 4'b0111);
    drive("msw", 1, 1, 0, 0, '0);
    drive("msw2", 1, 1, 0, 0, '0);

    // Random mix, dir toggling and mode changes included.
    for (int i = 0; i < 300; i++)
      drive("rnd", 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), W'($urandom));

    // Asynchronous reset mid-count.
    drive("aload", 0, 0, 0, 1, 4'b1110);
    rst_n = 1'b0; #1;
    check_eq("arst_out", 32'(out), 32'h0);
    check_eq("arst_wrap", 32'(wrap), 32'h0);
    check_eq("arst_phase", 32'(phase), 32'h0);
    release_reset();
    drive("resume", 1, 0, 0, 0, '0);

    // Asynchronous reset clears a live wrap pulse.
    drive("wload", 0, 0, 1, 1, 4'b0000);
    drive("wstep", 1, 0, 1, 0, '0);
    rst_n = 1'b0; #1;
    check_eq("arst2_wrap", 32'(wrap), 32'h0);
    check_eq("arst2_out", 32'(out), 32'h0);
    release_reset();

    check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
